// File: rtl/aemb2_xwb_arb.sv
// Two-master Wishbone arbiter: merges the AEMB2 instruction and data ports onto one
// shared bus, preferring data but forcing an instruction grant after STARVE data grants.
module aemb2_xwb_arb #(
    parameter int AW     = 32,
    parameter int STARVE = 4
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,

    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,

    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o,

    output logic          xwb_cyc_o,
    output logic          xwb_stb_o,
    output logic          xwb_wre_o,
    output logic [3:0]    xwb_sel_o,
    output logic [AW-1:2] xwb_adr_o,
    output logic [31:0]   xwb_dat_o,
    output logic          xwb_tga_o,
    input  logic [31:0]   xwb_dat_i,
    input  logic          xwb_ack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_C = 4'(STARVE);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:2]   adr_q, adr_d;
    logic            wre_q, wre_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     dat_q, dat_d;
    logic            grant_i, grant_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iwb_stb_i && dwb_stb_i) begin
                    state_d = (cnt_q < STARVE_C) ? GNT_D : GNT_I;
                end else if (dwb_stb_i) begin
                    state_d = GNT_D;
                end else if (iwb_stb_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                if (xwb_ack_i || !iwb_stb_i) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (xwb_ack_i || !dwb_stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus controls depend on the state register alone; acks pass straight through to the owner.
    always_comb begin
        xwb_cyc_o = (state_q != IDLE);
        xwb_stb_o = (state_q != IDLE);
        xwb_tga_o = (state_q == GNT_D);
        iwb_ack_o = (state_q == GNT_I) && xwb_ack_i;
        dwb_ack_o = (state_q == GNT_D) && xwb_ack_i;
    end

    assign iwb_dat_o = xwb_dat_i;
    assign dwb_dat_o = xwb_dat_i;

    assign grant_i = (state_q == IDLE) && (state_d == GNT_I);
    assign grant_d = (state_q == IDLE) && (state_d == GNT_D);

    // Request fields are captured only on grant entry and held for the whole transfer.
    always_comb begin
        cnt_d = cnt_q;
        adr_d = adr_q;
        wre_d = wre_q;
        sel_d = sel_q;
        dat_d = dat_q;
        if (grant_i) begin
            cnt_d = 4'd0;
            adr_d = iwb_adr_i;
            wre_d = 1'b0;
            sel_d = 4'hF;
            dat_d = 32'd0;
        end else if (grant_d) begin
            if (iwb_stb_i) begin
                cnt_d = (cnt_q >= STARVE_C) ? STARVE_C : cnt_q + 4'd1;
            end
            adr_d = dwb_adr_i;
            wre_d = dwb_wre_i;
            sel_d = dwb_sel_i;
            dat_d = dwb_dat_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            cnt_q <= 4'd0;
            adr_q <= '0;
            wre_q <= 1'b0;
            sel_q <= 4'd0;
            dat_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            wre_q <= wre_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
        end
    end

    assign xwb_adr_o = adr_q;
    assign xwb_wre_o = wre_q;
    assign xwb_sel_o = sel_q;
    assign xwb_dat_o = dat_q;

endmodule

// File: tb/tb_aemb2_xwb_arb.sv
// Self-checking bench for aemb2_xwb_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level ownership model.
module tb_aemb2_xwb_arb;

    localparam int AW     = 32;
    localparam int STARVE = 4;

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i;
    logic          iwb_stb_i;
    logic [AW-1:2] iwb_adr_i;
    logic          iwb_ack_o;
    logic [31:0]   iwb_dat_o;
    logic          dwb_stb_i;
    logic          dwb_wre_i;
    logic [3:0]    dwb_sel_i;
    logic [AW-1:2] dwb_adr_i;
    logic [31:0]   dwb_dat_i;
    logic          dwb_ack_o;
    logic [31:0]   dwb_dat_o;
    logic          xwb_cyc_o;
    logic          xwb_stb_o;
    logic          xwb_wre_o;
    logic [3:0]    xwb_sel_o;
    logic [AW-1:2] xwb_adr_o;
    logic [31:0]   xwb_dat_o;
    logic          xwb_tga_o;
    logic [31:0]   xwb_dat_i;
    logic          xwb_ack_i;

    always #5 sys_clk_i = ~sys_clk_i;

    aemb2_xwb_arb #(.AW(AW), .STARVE(STARVE)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .iwb_stb_i (iwb_stb_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_ack_o (iwb_ack_o),
        .iwb_dat_o (iwb_dat_o),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_o (dwb_ack_o),
        .dwb_dat_o (dwb_dat_o),
        .xwb_cyc_o (xwb_cyc_o),
        .xwb_stb_o (xwb_stb_o),
        .xwb_wre_o (xwb_wre_o),
        .xwb_sel_o (xwb_sel_o),
        .xwb_adr_o (xwb_adr_o),
        .xwb_dat_o (xwb_dat_o),
        .xwb_tga_o (xwb_tga_o),
        .xwb_dat_i (xwb_dat_i),
        .xwb_ack_i (xwb_ack_i)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 instruction, 2 data) and the captured request.
    int            m_owner;
    int            m_cnt;
    logic [AW-1:2] m_adr;
    logic          m_wre;
    logic [3:0]    m_sel;
    logic [31:0]   m_dat;

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_adr   = '0;
        m_wre   = 1'b0;
        m_sel   = 4'd0;
        m_dat   = 32'd0;
    endtask

    task automatic model_clock();
        int   winner;
        logic own_stb;
        winner = 0;
        if (!sys_rst_i) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (iwb_stb_i && dwb_stb_i) winner = (m_cnt == STARVE) ? 1 : 2;
            else if (dwb_stb_i)         winner = 2;
            else if (iwb_stb_i)         winner = 1;
            if (winner == 1) begin
                m_adr = iwb_adr_i; m_wre = 1'b0; m_sel = 4'hF; m_dat = 32'd0;
                m_cnt = 0;
            end else if (winner == 2) begin
                m_adr = dwb_adr_i; m_wre = dwb_wre_i; m_sel = dwb_sel_i; m_dat = dwb_dat_i;
                if (iwb_stb_i && m_cnt < STARVE) m_cnt = m_cnt + 1;
            end
            m_owner = winner;
        end else begin
            own_stb = (m_owner == 1) ? iwb_stb_i : dwb_stb_i;
            if (xwb_ack_i || !own_stb) m_owner = 0;
        end
    endtask

    task automatic compare_all();
        check("cyc",  xwb_cyc_o, m_owner != 0);
        check("stb",  xwb_stb_o, m_owner != 0);
        check("tga",  xwb_tga_o, m_owner == 2);
        check("adr",  xwb_adr_o, m_adr);
        check("wre",  xwb_wre_o, m_wre);
        check("sel",  xwb_sel_o, m_sel);
        check("wdat", xwb_dat_o, m_dat);
        check("iack", iwb_ack_o, (m_owner == 1) && xwb_ack_i);
        check("dack", dwb_ack_o, (m_owner == 2) && xwb_ack_i);
        check("idat", iwb_dat_o, xwb_dat_i);
        check("ddat", dwb_dat_o, xwb_dat_i);
    endtask

    // Inputs are set at the falling edge; outputs are compared 1 ns later, then the clock advances.
    task automatic cyc_step();
        #1;
        compare_all();
        @(posedge sys_clk_i);
        model_clock();
        @(negedge sys_clk_i);
    endtask

    logic [31:0] rnd;
    logic        order_q[$];
    logic        exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_i = 1'b0;
        iwb_stb_i = 1'b0; iwb_adr_i = '0;
        dwb_stb_i = 1'b0; dwb_wre_i = 1'b0; dwb_sel_i = 4'd0; dwb_adr_i = '0; dwb_dat_i = 32'd0;
        xwb_dat_i = 32'h0BAD_F00D; xwb_ack_i = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk_i);
        #1;
        compare_all();
        @(negedge sys_clk_i);
        sys_rst_i = 1'b1;

        // Single instruction fetch acked two cycles into the grant.
        iwb_stb_i = 1'b1; iwb_adr_i = 30'h100;
        cyc_step();
        #1;
        check("t051_stb", xwb_stb_o, 1'b1);
        check("t051_adr", xwb_adr_o, 30'h100);
        check("t051_tga", xwb_tga_o, 1'b0);
        cyc_step();
        xwb_ack_i = 1'b1;
        #1;
        check("t051_iack", iwb_ack_o, 1'b1);
        check("t051_dack", dwb_ack_o, 1'b0);
        cyc_step();
        iwb_stb_i = 1'b0; xwb_ack_i = 1'b0;
        cyc_step();

        // Both masters requesting continuously with immediate acks.
        iwb_stb_i = 1'b1; dwb_stb_i = 1'b1; xwb_ack_i = 1'b1;
        dwb_adr_i = 30'h2000; iwb_adr_i = 30'h300;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (xwb_stb_o) order_q.push_back(xwb_tga_o);
            cyc_step();
        end
        check("t052_count", order_q.size(), 10);
        for (int g = 0; g < 10 && g < order_q.size(); g++) begin
            check($sformatf("t052_grant%0d", g), order_q[g], exp_order[g]);
        end
        iwb_stb_i = 1'b0; dwb_stb_i = 1'b0; xwb_ack_i = 1'b0;
        cyc_step();

        // Data write fields must hold even when the master changes them mid-grant.
        dwb_stb_i = 1'b1; dwb_wre_i = 1'b1; dwb_sel_i = 4'h3; dwb_dat_i = 32'hDEAD_BEEF; dwb_adr_i = 30'h55;
        cyc_step();
        dwb_dat_i = 32'h1234_5678; dwb_sel_i = 4'hF; dwb_wre_i = 1'b0; dwb_adr_i = 30'h66;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t053_dat", xwb_dat_o, 32'hDEAD_BEEF);
            check("t053_wre", xwb_wre_o, 1'b1);
            check("t053_sel", xwb_sel_o, 4'h3);
            check("t053_adr", xwb_adr_o, 30'h55);
            cyc_step();
        end
        xwb_ack_i = 1'b1;
        #1;
        check("t053_dack", dwb_ack_o, 1'b1);
        cyc_step();
        dwb_stb_i = 1'b0; xwb_ack_i = 1'b0;
        cyc_step();

        // Data master abandons its request; a late ack must not leak through.
        dwb_stb_i = 1'b1;
        cyc_step();
        dwb_stb_i = 1'b0;
        #1;
        check("t054_stb_in_grant", xwb_stb_o, 1'b1);
        check("t054_dack", dwb_ack_o, 1'b0);
        cyc_step();
        xwb_ack_i = 1'b1;
        #1;
        check("t054_idle", xwb_stb_o, 1'b0);
        check("t054_late_dack", dwb_ack_o, 1'b0);
        check("t054_late_iack", iwb_ack_o, 1'b0);
        cyc_step();
        xwb_ack_i = 1'b0;

        // Build up the starvation count, then reset in the middle of an instruction grant.
        iwb_stb_i = 1'b1; dwb_stb_i = 1'b1; xwb_ack_i = 1'b1;
        repeat (4) cyc_step();
        dwb_stb_i = 1'b0; xwb_ack_i = 1'b0;
        cyc_step();
        xwb_ack_i = 1'b1;
        #1;
        check("t055_iack_before", iwb_ack_o, 1'b1);
        #1;
        sys_rst_i = 1'b0;
        model_reset();
        #1;
        check("t055_stb", xwb_stb_o, 1'b0);
        check("t055_cyc", xwb_cyc_o, 1'b0);
        check("t055_iack", iwb_ack_o, 1'b0);
        check("t055_adr", xwb_adr_o, 30'h0);
        check("t055_sel", xwb_sel_o, 4'h0);
        @(negedge sys_clk_i);
        dwb_stb_i = 1'b1;
        repeat (2) cyc_step();
        sys_rst_i = 1'b1; xwb_ack_i = 1'b0;
        cyc_step();
        #1;
        check("t055_first_data", xwb_tga_o, 1'b1);
        check("t055_first_stb", xwb_stb_o, 1'b1);
        xwb_ack_i = 1'b1;
        cyc_step();
        iwb_stb_i = 1'b0; dwb_stb_i = 1'b0; xwb_ack_i = 1'b0;
        cyc_step();

        // Randomized traffic with sticky strobes, random acks and occasional aborts.
        for (int c = 0; c < 800; c++) begin
            iwb_stb_i = iwb_stb_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
            dwb_stb_i = dwb_stb_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
            rnd = $urandom; iwb_adr_i = rnd[31:2];
            rnd = $urandom; dwb_adr_i = rnd[31:2];
            dwb_dat_i = $urandom;
            rnd = $urandom; dwb_sel_i = rnd[3:0]; dwb_wre_i = rnd[4];
            xwb_dat_i = $urandom;
            xwb_ack_i = ($urandom_range(0, 2) == 0);
            cyc_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/aemb2_xwb_arb.md
AEMB2_XWB_ARB -- requirements
Module: aemb2_xwb_arb

Interface
REQ-001 The block SHALL have a parameter AW, default 32, giving the shared-bus byte-address width; address ports are [AW-1:2].
REQ-002 The block SHALL have a parameter STARVE, default 4, range 1..15, giving the maximum consecutive data grants while instruction is pending.
REQ-003 sys_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 iwb_stb_i  in  1  instruction-fetch request strobe.
REQ-006 iwb_adr_i  in  AW-2  instruction word address.
REQ-007 iwb_ack_o  out  1  instruction transfer acknowledge.
REQ-008 iwb_dat_o  out  32  instruction read data.
REQ-009 dwb_stb_i  in  1  data request strobe.
REQ-010 dwb_wre_i  in  1  data write enable.
REQ-011 dwb_sel_i  in  4  data byte selects.
REQ-012 dwb_adr_i  in  AW-2  data word address.
REQ-013 dwb_dat_i  in  32  data write data.
REQ-014 dwb_ack_o  out  1  data transfer acknowledge.
REQ-015 dwb_dat_o  out  32  data read data.
REQ-016 xwb_cyc_o, xwb_stb_o, xwb_wre_o  out  1 each  shared-bus cycle, strobe and write enable.
REQ-017 xwb_sel_o  out  4  shared-bus byte selects.
REQ-018 xwb_adr_o  out  AW-2  shared-bus word address.
REQ-019 xwb_dat_o  out  32  shared-bus write data.
REQ-020 xwb_tga_o  out  1  owner tag: 0 = instruction, 1 = data.
REQ-021 xwb_dat_i  in  32  shared-bus read data.
REQ-022 xwb_ack_i  in  1  shared-bus acknowledge.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, GNT_I and GNT_D.
REQ-024 In IDLE, if no strobe is high, the FSM SHALL remain in IDLE.
REQ-025 In IDLE, if exactly one strobe is high, the FSM SHALL grant that master on the next edge.
REQ-026 In IDLE, if both strobes are high and cnt < STARVE, the FSM SHALL grant data.
REQ-027 In IDLE, if both strobes are high and cnt == STARVE, the FSM SHALL grant instruction.
REQ-028 On entry to a GNT state, the block SHALL register the granted master's address into xwb_adr_o.
REQ-029 On entry to GNT_D, the block SHALL register dwb_wre_i, dwb_sel_i and dwb_dat_i into xwb_wre_o, xwb_sel_o and xwb_dat_o.
REQ-030 On entry to GNT_I, the block SHALL set xwb_wre_o=0, xwb_sel_o=4'hF and xwb_dat_o=0.
REQ-031 xwb_cyc_o and xwb_stb_o SHALL be high exactly while the state is not IDLE, decoded from the state register only.
REQ-032 xwb_tga_o SHALL be 1 in GNT_D and 0 otherwise.
REQ-033 Latency: a strobe sampled at edge n SHALL give xwb_stb_o high after edge n.
REQ-034 The registered request fields SHALL stay constant for the whole grant.
REQ-035 In a GNT state, xwb_ack_i SHALL be forwarded combinationally to the owner's ack output only.
REQ-036 The non-owner ack output SHALL be 0 at all times.
REQ-037 In IDLE, xwb_ack_i SHALL be ignored and both ack outputs SHALL be 0.
REQ-038 iwb_dat_o and dwb_dat_o SHALL both equal xwb_dat_i at all times.
REQ-039 When xwb_ack_i is high in a GNT state, the FSM SHALL return to IDLE on the next edge.
REQ-040 There SHALL be at least one IDLE cycle between consecutive shared-bus transfers.
REQ-041 If the owner's strobe drops before ack, the FSM SHALL abort to IDLE on the next edge with no ack forwarded.
REQ-042 An ack coincident with the owner's strobe drop SHALL still be forwarded.
REQ-043 Starvation counter cnt, 4-bit: it SHALL increment, saturating at STARVE, on each grant to data made while iwb_stb_i is high.
REQ-044 cnt SHALL clear to 0 on each grant to instruction.
REQ-045 cnt SHALL hold its value on grants to data made while iwb_stb_i is low.

Reset
REQ-046 While sys_rst_i is low, the state SHALL be IDLE and cnt SHALL be 0.
REQ-047 While sys_rst_i is low, all registered xwb outputs SHALL be 0 and both ack outputs SHALL be 0, independent of the clock.
REQ-048 Assertion of sys_rst_i during a grant SHALL drop xwb_cyc_o and xwb_stb_o immediately.
REQ-049 A pending xwb_ack_i during reset SHALL NOT be forwarded.
REQ-050 After reset deasserts, arbitration SHALL resume from IDLE on the first clock edge.

Verification
REQ-051 iwb_stb_i=1, iwb_adr_i=0x100, ack after 2 cycles -> xwb_stb_o one cycle after request; xwb_adr_o=0x100, tga=0; iwb_ack_o pulses with xwb_ack_i; dwb_ack_o stays 0.
REQ-052 Both strobes held continuously high, single-cycle acks, STARVE=4 -> grant order D,D,D,D,I,D,D,D,D,I; each transfer separated by one IDLE cycle.
REQ-053 dwb write, sel=4'h3, dat=0xDEADBEEF, then dwb_dat_i changed mid-grant -> xwb_dat_o stays 0xDEADBEEF with wre=1 and sel=3 until ack.
REQ-054 dwb_stb_i dropped one cycle into grant with no ack -> FSM returns to IDLE; dwb_ack_o never asserted; a later xwb_ack_i is ignored.
REQ-055 sys_rst_i pulled low mid-GNT_I with xwb_ack_i=1 -> xwb_stb_o=0 and iwb_ack_o=0 immediately; after release, cnt=0 and the next simultaneous request goes to data.
